// File: rtl/vslc_timer_bank.sv
// VSLC PLC timer bank: TON / TOF / TP channels on a shared prescaled tick.
// One config write port, registered q outputs, elapsed-time read mux.
module vslc_timer_bank #(
  parameter int NUM_TIMERS = 4,
  parameter int WIDTH      = 8,
  parameter int PRESCALE   = 1000,
  localparam int SEL_W     = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  cfg_we,
  input  logic [SEL_W-1:0]      cfg_sel,
  input  logic [1:0]            cfg_mode,
  input  logic [WIDTH-1:0]      cfg_preset,
  input  logic [NUM_TIMERS-1:0] in_en,
  output logic [NUM_TIMERS-1:0] q,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [WIDTH-1:0]      rd_elapsed,
  output logic                  tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    M_OFF = 2'b00,
    M_TON = 2'b01,
    M_TOF = 2'b10,
    M_TP  = 2'b11
  } mode_e;

  logic [PW-1:0]         pre_cnt;
  logic [WIDTH-1:0]      et      [NUM_TIMERS];
  logic [WIDTH-1:0]      et_nx   [NUM_TIMERS];
  logic [WIDTH-1:0]      et_adv  [NUM_TIMERS];
  logic [WIDTH-1:0]      preset  [NUM_TIMERS];
  logic [WIDTH-1:0]      pr_nx   [NUM_TIMERS];
  mode_e                 mode    [NUM_TIMERS];
  mode_e                 md_nx   [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] q_r;
  logic [NUM_TIMERS-1:0] q_nx;
  logic [NUM_TIMERS-1:0] in_d;
  logic [NUM_TIMERS-1:0] in_d_nx;

  assign tick = ena & (pre_cnt == LAST);
  assign q    = q_r;

  // Timebase prescaler, frozen while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (ena) begin
      pre_cnt <= (pre_cnt == LAST) ? '0 : pre_cnt + PW'(1);
    end
  end

  // Per-channel next state; a config write wins over the timer function
  always_comb begin
    q_nx    = q_r;
    in_d_nx = in_d;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      et_adv[i] = (tick && (et[i] < preset[i])) ? et[i] + WIDTH'(1) : et[i];
      et_nx[i]  = et[i];
      pr_nx[i]  = preset[i];
      md_nx[i]  = mode[i];
      if (cfg_we && (cfg_sel == SEL_W'(i))) begin
        md_nx[i]   = mode_e'(cfg_mode);
        pr_nx[i]   = cfg_preset;
        et_nx[i]   = '0;
        q_nx[i]    = 1'b0;
        in_d_nx[i] = in_en[i];
      end else if (ena) begin
        in_d_nx[i] = in_en[i];
        unique case (mode[i])
          M_OFF: begin
            et_nx[i] = '0;
            q_nx[i]  = 1'b0;
          end
          M_TON: begin
            if (!in_en[i]) begin
              et_nx[i] = '0;
              q_nx[i]  = 1'b0;
            end else begin
              et_nx[i] = et_adv[i];
              q_nx[i]  = (et_adv[i] == preset[i]);
            end
          end
          M_TOF: begin
            if (in_en[i]) begin
              et_nx[i] = '0;
              q_nx[i]  = 1'b1;
            end else if (q_r[i]) begin
              et_nx[i] = et_adv[i];
              q_nx[i]  = (et_adv[i] != preset[i]);
            end
          end
          M_TP: begin
            if (q_r[i]) begin
              et_nx[i] = et_adv[i];
              q_nx[i]  = (et_adv[i] != preset[i]);
            end else if (in_en[i] && !in_d[i] && (preset[i] != '0)) begin
              et_nx[i] = '0;
              q_nx[i]  = 1'b1;
            end else if (!in_en[i]) begin
              et_nx[i] = '0;
            end
          end
        endcase
      end
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r  <= '0;
      in_d <= '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        et[i]     <= '0;
        preset[i] <= '0;
        mode[i]   <= M_OFF;
      end
    end else begin
      q_r  <= q_nx;
      in_d <= in_d_nx;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        et[i]     <= et_nx[i];
        preset[i] <= pr_nx[i];
        mode[i]   <= md_nx[i];
      end
    end
  end

  // Elapsed readback; out-of-range select reads zero
  always_comb begin
    rd_elapsed = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (rd_sel == SEL_W'(i)) rd_elapsed = et[i];
    end
  end

endmodule
